// File: rtl/std_dffpipe_pkg.sv
// std_pkg: shared constants and helpers for the std_* retiming blocks
// Contents: STD_DFFPIPE_MIN_DEPTH (smallest legal pipeline depth),
//           clog2_cnt(depth) (bits needed to hold a count of 0..depth)
package std_pkg;
   localparam int STD_DFFPIPE_MIN_DEPTH = 1;
   function automatic int clog2_cnt(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/std_dffpipe_stage.sv
// std_dffpipe_stage: one data/valid register pair of the elastic pipeline
// Ports: clk, reset (async, active-high; data -> RST_VAL, v -> 0),
//        load (capture din, set v), clr (drop v; ignored when load is high),
//        din (stage input data), data/v (registered stage state)
// Macro STD_DFFPIPE_CLR_DATA_EN: clr also reloads data with RST_VAL
module std_dffpipe_stage
   import std_pkg::*;
#(
   parameter int DW = 8,
   parameter logic [DW-1:0] RST_VAL = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          clr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] data,
   output logic          v
);
   logic [DW-1:0] data_d, data_q;
   logic v_d, v_q;
   always_comb begin
      v_d = load | (v_q & ~clr);
`ifdef STD_DFFPIPE_CLR_DATA_EN
      data_d = load ? din : clr ? RST_VAL : data_q;
`else
      data_d = load ? din : data_q;
`endif
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= RST_VAL;
         v_q <= 1'b0;
      end else begin
         data_q <= data_d;
         v_q <= v_d;
      end
   end
   assign data = data_q;
   assign v = v_q;
endmodule

// File: rtl/std_dffpipe.sv
// std_dffpipe: DEPTH-stage DW-wide elastic register pipeline with bubble collapse
// Ports: clk, reset (async, active-high), flush (sync clear of all valids),
//        in_valid/in_ready/d (upstream handshake; stage 0 captures INVERT ? ~d : d),
//        out_valid/out_ready/q (downstream handshake; q is the last stage register),
//        count (registered number of valid stages)
// Macro STD_DFFPIPE_CLR_DATA_EN: flush and drain also reset stage data to RST_VAL
module std_dffpipe
   import std_pkg::*;
#(
   parameter int DW = 8,
   parameter int DEPTH = 3,
   parameter bit INVERT = 1'b0,
   parameter logic [DW-1:0] RST_VAL = '0,
   localparam int CW = clog2_cnt(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] d,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] q,
   output logic [CW-1:0] count
);
   if (DEPTH < STD_DFFPIPE_MIN_DEPTH || DW < 1) begin : g_bad_param
      $error("std_dffpipe: DEPTH and DW must be >= 1");
   end
   logic [DW-1:0] data [DEPTH];
   logic [DEPTH-1:0] v, adv, load, clr, v_nxt;
   logic [CW-1:0] count_d, count_q;
   logic acc;
   // advance resolves from the output side backward so a stage can move
   // into a slot that is being vacated in the same cycle
   always_comb begin
      adv = '0;
      adv[DEPTH-1] = v[DEPTH-1] & out_ready;
      for (int i = DEPTH - 2; i >= 0; i--) adv[i] = v[i] & (~v[i+1] | adv[i+1]);
   end
   assign in_ready = ~v[0] | adv[0];
   assign acc = in_valid & in_ready & ~flush;
   always_comb begin
      load = '0;
      load[0] = acc;
      for (int i = 1; i < DEPTH; i++) load[i] = ~flush & adv[i-1];
      clr = {DEPTH{flush}} | (adv & ~load);
      v_nxt = load | (v & ~clr);
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) count_d = count_d + CW'(v_nxt[i]);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else count_q <= count_d;
   end
   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic [DW-1:0] din;
      if (g == 0) begin : g_in
         assign din = INVERT ? ~d : d;
      end else begin : g_mid
         assign din = data[g-1];
      end
      std_dffpipe_stage #(.DW(DW), .RST_VAL(RST_VAL)) u_stage (
         .clk(clk),
         .reset(reset),
         .load(load[g]),
         .clr(clr[g]),
         .din(din),
         .data(data[g]),
         .v(v[g])
      );
   end
   assign q = data[DEPTH-1];
   assign out_valid = v[DEPTH-1];
   assign count = count_q;
endmodule

// File: tb/tb_std_dffpipe.sv
// tb_std_dffpipe: directed bench for std_dffpipe, positional item model plus literal checks
module tb_std_dffpipe;
   localparam int DEPTH = 3;
   localparam logic [7:0] RV = 8'hA5;
`ifdef STD_DFFPIPE_CLR_DATA_EN
   localparam logic [7:0] FL0 = RV;
   localparam logic [7:0] FL1 = RV;
`else
   localparam logic [7:0] FL0 = 8'h11;
   localparam logic [7:0] FL1 = 8'hEE;
`endif
   logic clk, reset, flush, in_valid, out_ready;
   logic [7:0] d, q0, q1;
   logic ir0, ir1, ov0, ov1;
   logic [1:0] cnt0, cnt1;
   int n_tests = 0, n_fail = 0;
   bit started = 0;
   logic [7:0] dq[$];
   int pq[$];
   int nxt[DEPTH];
   bit pop_m, rdy_m;

   std_dffpipe #(.DW(8), .DEPTH(DEPTH), .INVERT(1'b0), .RST_VAL(RV)) dut0 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
      .d(d), .out_valid(ov0), .out_ready(out_ready), .q(q0), .count(cnt0));
   std_dffpipe #(.DW(8), .DEPTH(DEPTH), .INVERT(1'b1), .RST_VAL(RV)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
      .d(d), .out_valid(ov1), .out_ready(out_ready), .q(q1), .count(cnt1));

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // items are an ordered list with stage positions; each item steps forward
   // unless the position ahead is still occupied after the item ahead has moved
   task automatic plan(input bit ordy);
      int lim;
      lim = DEPTH;
      pop_m = 0;
      for (int j = 0; j < pq.size(); j++) begin
         if (j == 0 && pq[0] == DEPTH - 1 && ordy) begin
            pop_m = 1;
            nxt[0] = DEPTH;
         end else nxt[j] = (pq[j] + 1 < lim) ? pq[j] + 1 : pq[j];
         lim = nxt[j];
      end
      rdy_m = pq.size() == 0 || nxt[pq.size()-1] > 0;
   endtask

   task automatic update();
      int np[$];
      logic [7:0] nd[$];
      bit acc;
      plan(out_ready);
      acc = in_valid && rdy_m && !flush;
      for (int j = 0; j < pq.size(); j++)
         if (!(j == 0 && pop_m)) begin
            np.push_back(nxt[j]);
            nd.push_back(dq[j]);
         end
      pq = np;
      dq = nd;
      if (flush) begin
         pq.delete();
         dq.delete();
      end else if (acc) begin
         pq.push_back(0);
         dq.push_back(d);
      end
   endtask

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         pq.delete();
         dq.delete();
      end else update();
   end

   initial forever begin
      bit ov;
      logic [7:0] inv;
      @(negedge clk);
      if (started && !reset) begin
         plan(out_ready);
         ov = pq.size() > 0 && pq[0] == DEPTH - 1;
         chk("m_out_valid0", ov0, ov);
         chk("m_out_valid1", ov1, ov);
         chk("m_in_ready0", ir0, rdy_m);
         chk("m_in_ready1", ir1, rdy_m);
         chk("m_count0", cnt0, pq.size());
         chk("m_count1", cnt1, pq.size());
         if (ov) begin
            inv = ~dq[0];
            chk("m_q0", q0, dq[0]);
            chk("m_q1", q1, inv);
         end
      end
   end

   task automatic cyc(input bit iv, input logic [7:0] dd, input bit ordy, input bit fl);
      in_valid = iv;
      d = dd;
      out_ready = ordy;
      flush = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1;
      flush = 0;
      in_valid = 0;
      out_ready = 0;
      d = 0;
      #1;
      chk("rst_q0", q0, RV);
      chk("rst_q1", q1, RV);
      chk("rst_ov", ov0, 0);
      chk("rst_cnt", cnt0, 0);
      chk("rst_ir", ir0, 1);
      repeat (2) @(posedge clk);
      #1 reset = 0;
      started = 1;
      // latency and inversion
      cyc(1, 8'h0F, 1, 0);
      chk("lat_ov_c1", ov1, 0);
      cyc(0, 8'h00, 1, 0);
      chk("lat_ov_c2", ov1, 0);
      cyc(0, 8'h00, 1, 0);
      chk("lat_ov_c3", ov1, 1);
      chk("lat_q1", q1, 8'hF0);
      chk("lat_q0", q0, 8'h0F);
      for (int i = 0; i < 10; i++) cyc(1, 8'(i), 1, 0);
      chk("b2b_q1", q1, 8'hF8);
      chk("b2b_cnt", cnt0, 3);
      repeat (4) cyc(0, 8'h00, 1, 0);
      chk("b2b_drained", cnt0, 0);
      // full stall and release
      cyc(1, 8'h11, 0, 0);
      cyc(1, 8'h22, 0, 0);
      cyc(1, 8'h33, 0, 0);
      chk("stall_cnt", cnt0, 3);
      chk("stall_ir", ir0, 0);
      chk("stall_q", q0, 8'h11);
      in_valid = 0;
      out_ready = 1;
      #1;
      chk("release_ir", ir0, 1);
      cyc(0, 8'h00, 1, 0);
      chk("release_q22", q0, 8'h22);
      cyc(0, 8'h00, 1, 0);
      chk("release_q33", q0, 8'h33);
      cyc(0, 8'h00, 1, 0);
      chk("release_empty", ov0, 0);
      // bubble collapse
      cyc(1, 8'h44, 0, 0);
      cyc(0, 8'h00, 0, 0);
      cyc(0, 8'h00, 0, 0);
      cyc(1, 8'h55, 0, 0);
      cyc(0, 8'h00, 0, 0);
      chk("bub_cnt", cnt0, 2);
      chk("bub_q", q0, 8'h44);
      cyc(0, 8'h00, 1, 0);
      chk("bub_q55", q0, 8'h55);
      chk("bub_ov55", ov0, 1);
      cyc(0, 8'h00, 1, 0);
      chk("bub_empty", ov0, 0);
      // flush
      cyc(1, 8'h11, 0, 0);
      cyc(1, 8'h22, 0, 0);
      cyc(1, 8'h33, 0, 0);
      cyc(1, 8'h66, 0, 1);
      chk("fl_cnt", cnt0, 0);
      chk("fl_ov", ov0, 0);
      chk("fl_q0", q0, FL0);
      chk("fl_q1", q1, FL1);
      cyc(1, 8'h77, 1, 1);
      chk("fl_accept_drop", cnt0, 0);
      repeat (3) cyc(0, 8'h00, 1, 0);
      chk("fl_never_out", ov0, 0);
      // simultaneous accept and transfer
      cyc(1, 8'h81, 0, 0);
      cyc(1, 8'h82, 0, 0);
      cyc(1, 8'h83, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(1, 8'h90 + 8'(i), 1, 0);
         chk("sim_cnt", cnt0, 3);
      end
      chk("sim_q", q0, 8'h97);
      repeat (4) cyc(0, 8'h00, 1, 0);
      chk("sim_drained", cnt0, 0);
      // reset mid-stream
      cyc(1, 8'hA1, 1, 0);
      cyc(1, 8'hA2, 1, 0);
      #2 reset = 1;
      #1;
      chk("mrst_q0", q0, RV);
      chk("mrst_q1", q1, RV);
      chk("mrst_ov", ov0, 0);
      chk("mrst_cnt", cnt0, 0);
      chk("mrst_ir", ir0, 1);
      @(posedge clk);
      #1 reset = 0;
      cyc(1, 8'hC3, 1, 0);
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 1, 0);
      chk("post_rst_q", q0, 8'hC3);
      chk("post_rst_ov", ov0, 1);
      cyc(0, 8'h00, 1, 0);
      chk("post_rst_empty", cnt0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
